inst_buffer_ctrl: RTL and testbench

//  In-order instruction buffer and sequencer between fetch and the decoder slots.

---
 rtl/inst_buffer_ctrl.sv | 142 ++++++++++++++
 tb/tb_inst_buffer_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// inst_buffer_ctrl
// In-order instruction buffer sitting between fetch and the decoder slots.
// Fetched instruction/PC pairs are queued in a circular array. The oldest
// entries (up to DISP_W) are shown to the decoders combinationally from the
// head pointer. Entries retire as dispatch consumes them. A flush empties the
// buffer, and dispatching a WFI stops the front end until reset.
//
// Ports
//   clock          : system clock, all state updates on posedge
//   reset          : synchronous, active-high
//   fetch_valid    : per-slot fetch valid, contiguous from slot 0 (oldest)
//   fetch_inst     : fetched RV32 instruction words
//   fetch_pc       : PC of each fetched instruction
//   fetch_ready    : a full fetch group can be accepted this cycle
//   dec_valid      : per decoder slot valid, contiguous from slot 0
//   dec_inst       : instruction presented to each decoder slot
//   dec_pc         : PC presented to each decoder slot
//   dispatch_count : number of decoder slots consumed this cycle
//   flush          : discard all buffered instructions
//   halted         : a WFI has been dispatched; front end is stopped
//   count          : current buffer occupancy
// ---------------------------------------------------------------------------
module inst_buffer_ctrl #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int DISP_W  = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [FETCH_W-1:0]           fetch_valid,
  input  logic [FETCH_W-1:0][31:0]     fetch_inst,
  input  logic [FETCH_W-1:0][31:0]     fetch_pc,
  output logic                         fetch_ready,
  output logic [DISP_W-1:0]            dec_valid,
  output logic [DISP_W-1:0][31:0]      dec_inst,
  output logic [DISP_W-1:0][31:0]      dec_pc,
  input  logic [$clog2(DISP_W+1)-1:0]  dispatch_count,
  input  logic                         flush,
  output logic                         halted,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NW = $clog2(DISP_W+1);
  localparam int FW = $clog2(FETCH_W+1);
  localparam logic [31:0]   WFI_INST  = 32'h10500073;
  localparam logic [CW-1:0] READY_LIM = CW'(DEPTH - FETCH_W);

  logic [31:0]   r_memInst [DEPTH];
  logic [31:0]   r_memPc   [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_halted;

  logic [FW-1:0] w_nIn;
  logic [NW-1:0] w_nValid;
  logic [NW-1:0] w_nOut;
  logic          w_wfiSeen;
  logic          w_wfiHit;
  logic          w_enq;

  assign count       = r_count;
  assign halted      = r_halted;
  // Space check uses only registered occupancy; a slot freed by dispatch
  // in the same cycle does not count towards accepting fetch.
  assign fetch_ready = !r_halted && (r_count <= READY_LIM);
  assign w_enq       = fetch_ready && !flush;

  // Count incoming instructions in the fetch group.
  always_comb begin
    w_nIn = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (fetch_valid[i]) w_nIn = w_nIn + FW'(1);
    end
  end

  // Show-ahead presentation from head. A WFI closes its group so that
  // nothing younger can be dispatched alongside it.
  always_comb begin
    dec_valid = '0;
    dec_inst  = '0;
    dec_pc    = '0;
    w_wfiSeen = 1'b0;
    w_nValid  = '0;
    for (int i = 0; i < DISP_W; i++) begin
      dec_inst[i] = r_memInst[r_head + PW'(i)];
      dec_pc[i]   = r_memPc[r_head + PW'(i)];
      if (!r_halted && !w_wfiSeen && (CW'(i) < r_count)) begin
        dec_valid[i] = 1'b1;
        w_nValid     = w_nValid + NW'(1);
        if (dec_inst[i] == WFI_INST) w_wfiSeen = 1'b1;
      end
    end
  end

  // Clamp dispatch to what is actually valid, then see whether the
  // consumed slots include a WFI.
  always_comb begin
    w_nOut   = (dispatch_count < w_nValid) ? dispatch_count : w_nValid;
    w_wfiHit = 1'b0;
    for (int i = 0; i < DISP_W; i++) begin
      if (dec_valid[i] && (dec_inst[i] == WFI_INST) && (NW'(i) < w_nOut))
        w_wfiHit = 1'b1;
    end
  end

  // Pointer, occupancy and halt state. Reset beats flush, and flush
  // discards whatever enqueue/dequeue happened in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_halted <= 1'b0;
    end else if (flush) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
    end else begin
      r_head  <= r_head + PW'(w_nOut);
      if (w_enq) r_tail <= r_tail + PW'(w_nIn);
      r_count <= r_count + (w_enq ? CW'(w_nIn) : CW'(0)) - CW'(w_nOut);
      if (w_wfiHit) r_halted <= 1'b1;
    end
  end

  // Storage array; contents need no reset since validity comes from count.
  always_ff @(posedge clock) begin
    if (!reset && w_enq) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (fetch_valid[i]) begin
          r_memInst[r_tail + PW'(i)] <= fetch_inst[i];
          r_memPc[r_tail + PW'(i)]   <= fetch_pc[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inst_buffer_ctrl
// Directed testbench for inst_buffer_ctrl with DEPTH=8, FETCH_W=2, DISP_W=2.
// ---------------------------------------------------------------------------
module tb_inst_buffer_ctrl;

  localparam logic [31:0] WFI = 32'h10500073;

  logic              clock;
  logic              reset;
  logic [1:0]        fetch_valid;
  logic [1:0][31:0]  fetch_inst;
  logic [1:0][31:0]  fetch_pc;
  logic              fetch_ready;
  logic [1:0]        dec_valid;
  logic [1:0][31:0]  dec_inst;
  logic [1:0][31:0]  dec_pc;
  logic [1:0]        dispatch_count;
  logic              flush;
  logic              halted;
  logic [3:0]        count;

  int vectors = 0;
  int miscompares = 0;

  inst_buffer_ctrl #(.DEPTH(8), .FETCH_W(2), .DISP_W(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_valid    (fetch_valid),
    .fetch_inst     (fetch_inst),
    .fetch_pc       (fetch_pc),
    .fetch_ready    (fetch_ready),
    .dec_valid      (dec_valid),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .dispatch_count (dispatch_count),
    .flush          (flush),
    .halted         (halted),
    .count          (count)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // addi-style word tagged with the low PC bits so entries are distinguishable
  function automatic logic [31:0] mkInst(input logic [31:0] pc);
    return {pc[11:0], 20'h00013};
  endfunction

  // Drive one cycle of inputs, clock it, and settle 1 ns past the edge
  task automatic applyStimulus(input logic rst, input logic fl, input logic [1:0] fv,
                               input logic [31:0] pc0, input logic [31:0] pc1,
                               input logic [1:0] dc, input logic [1:0] wfiMask);
    reset          = rst;
    flush          = fl;
    fetch_valid    = fv;
    fetch_pc[0]    = pc0;
    fetch_pc[1]    = pc1;
    fetch_inst[0]  = wfiMask[0] ? WFI : mkInst(pc0);
    fetch_inst[1]  = wfiMask[1] ? WFI : mkInst(pc1);
    dispatch_count = dc;
    @(posedge clock);
    #1;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; fetch_valid = '0; fetch_inst = '0;
    fetch_pc = '0; dispatch_count = '0;

    // ---- 1: reset state, basic fetch/dispatch ----
    $display("[TB] test 1: reset and basic flow");
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 2'b00);
    checkOutput("rst_count", 64'(count), 0);
    checkOutput("rst_dec_valid", 64'(dec_valid), 0);
    checkOutput("rst_fetch_ready", 64'(fetch_ready), 1);
    checkOutput("rst_halted", 64'(halted), 0);
    applyStimulus(0, 0, 2'b11, 32'h0, 32'h4, 0, 2'b00);
    checkOutput("t1_dec_valid", 64'(dec_valid), 2'b11);
    checkOutput("t1_pc0", 64'(dec_pc[0]), 32'h0);
    checkOutput("t1_pc1", 64'(dec_pc[1]), 32'h4);
    checkOutput("t1_inst1", 64'(dec_inst[1]), 32'h00400013);
    checkOutput("t1_count", 64'(count), 2);
    applyStimulus(0, 0, 2'b00, 0, 0, 2, 2'b00);
    checkOutput("t1_drain_count", 64'(count), 0);
    checkOutput("t1_drain_valid", 64'(dec_valid), 0);

    // ---- 2: fill to full, overflow protection ----
    $display("[TB] test 2: fill and full");
    applyStimulus(0, 0, 2'b11, 32'h100, 32'h104, 0, 2'b00);
    applyStimulus(0, 0, 2'b11, 32'h108, 32'h10C, 0, 2'b00);
    applyStimulus(0, 0, 2'b11, 32'h110, 32'h114, 0, 2'b00);
    checkOutput("t2_count6", 64'(count), 6);
    checkOutput("t2_ready6", 64'(fetch_ready), 1);
    applyStimulus(0, 0, 2'b11, 32'h118, 32'h11C, 0, 2'b00);
    checkOutput("t2_count8", 64'(count), 8);
    checkOutput("t2_ready8", 64'(fetch_ready), 0);
    applyStimulus(0, 0, 2'b11, 32'h200, 32'h204, 0, 2'b00);
    checkOutput("t2_full_count", 64'(count), 8);
    checkOutput("t2_full_pc0", 64'(dec_pc[0]), 32'h100);
    applyStimulus(0, 0, 2'b11, 32'h200, 32'h204, 1, 2'b00);
    checkOutput("t2_count7", 64'(count), 7);
    checkOutput("t2_ready7", 64'(fetch_ready), 0);
    checkOutput("t2_pc0_after", 64'(dec_pc[0]), 32'h104);

    // ---- 3: steady 2-in/2-out across pointer wrap ----
    $display("[TB] test 3: steady streaming");
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 2'b00);
    applyStimulus(0, 0, 2'b11, 32'h0, 32'h4, 0, 2'b00);
    for (int k = 0; k < 10; k++) begin
      checkOutput("t3_pc0", 64'(dec_pc[0]), 64'(8 * k));
      checkOutput("t3_pc1", 64'(dec_pc[1]), 64'(8 * k + 4));
      applyStimulus(0, 0, 2'b11, 32'(8 * k + 8), 32'(8 * k + 12), 2, 2'b00);
      checkOutput("t3_count", 64'(count), 2);
    end

    // ---- 4: flush wins over same-cycle fetch and dispatch ----
    $display("[TB] test 4: flush");
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 2'b00);
    applyStimulus(0, 0, 2'b11, 32'h0, 32'h4, 0, 2'b00);
    applyStimulus(0, 0, 2'b11, 32'h8, 32'hC, 0, 2'b00);
    applyStimulus(0, 0, 2'b01, 32'h10, 32'h14, 0, 2'b00);
    checkOutput("t4_count5", 64'(count), 5);
    applyStimulus(0, 1, 2'b11, 32'h20, 32'h24, 2, 2'b00);
    checkOutput("t4_count", 64'(count), 0);
    checkOutput("t4_valid", 64'(dec_valid), 0);
    checkOutput("t4_ready", 64'(fetch_ready), 1);
    applyStimulus(0, 0, 2'b11, 32'h300, 32'h304, 0, 2'b00);
    checkOutput("t4_refill_pc0", 64'(dec_pc[0]), 32'h300);
    checkOutput("t4_refill_count", 64'(count), 2);

    // ---- 5: WFI handling and halt ----
    $display("[TB] test 5: WFI");
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 2'b00);
    applyStimulus(0, 0, 2'b11, 32'h0, 32'h4, 0, 2'b10);
    checkOutput("t5_wfi1_valid", 64'(dec_valid), 2'b11);
    applyStimulus(0, 0, 2'b00, 0, 0, 1, 2'b00);
    checkOutput("t5_wfi1_not_halted", 64'(halted), 0);
    checkOutput("t5_wfi1_count", 64'(count), 1);
    applyStimulus(0, 0, 2'b00, 0, 0, 2, 2'b00);
    checkOutput("t5_wfi1_halted", 64'(halted), 1);
    checkOutput("t5_wfi1_count0", 64'(count), 0);
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 2'b00);
    checkOutput("t5_rst_halted", 64'(halted), 0);
    applyStimulus(0, 0, 2'b11, 32'h10, 32'h14, 0, 2'b01);
    checkOutput("t5_wfi0_valid", 64'(dec_valid), 2'b01);
    applyStimulus(0, 0, 2'b00, 0, 0, 1, 2'b00);
    checkOutput("t5_halted", 64'(halted), 1);
    checkOutput("t5_ready", 64'(fetch_ready), 0);
    checkOutput("t5_valid", 64'(dec_valid), 0);
    checkOutput("t5_count", 64'(count), 1);
    applyStimulus(0, 0, 2'b11, 32'h40, 32'h44, 2, 2'b00);
    checkOutput("t5_ignored_count", 64'(count), 1);
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 2'b00);
    checkOutput("t5_flush_halted", 64'(halted), 1);
    checkOutput("t5_flush_count", 64'(count), 0);
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 2'b00);
    checkOutput("t5_reset_halted", 64'(halted), 0);
    checkOutput("t5_reset_ready", 64'(fetch_ready), 1);

    // ---- 6: underflow clamp and mid-stream reset ----
    $display("[TB] test 6: clamp and reset");
    applyStimulus(0, 0, 2'b01, 32'h40, 32'h44, 0, 2'b00);
    checkOutput("t6_count1", 64'(count), 1);
    checkOutput("t6_valid1", 64'(dec_valid), 2'b01);
    applyStimulus(0, 0, 2'b00, 0, 0, 2, 2'b00);
    checkOutput("t6_clamp_count", 64'(count), 0);
    applyStimulus(0, 0, 2'b00, 0, 0, 2, 2'b00);
    checkOutput("t6_empty_count", 64'(count), 0);
    checkOutput("t6_empty_valid", 64'(dec_valid), 0);
    applyStimulus(0, 0, 2'b11, 32'h50, 32'h54, 0, 2'b00);
    applyStimulus(0, 0, 2'b11, 32'h58, 32'h5C, 0, 2'b00);
    applyStimulus(0, 0, 2'b11, 32'h60, 32'h64, 0, 2'b00);
    checkOutput("t6_count6", 64'(count), 6);
    checkOutput("t6_pc0", 64'(dec_pc[0]), 32'h50);
    applyStimulus(1, 1, 2'b11, 32'h70, 32'h74, 1, 2'b00);
    checkOutput("t6_reset_count", 64'(count), 0);
    checkOutput("t6_reset_valid", 64'(dec_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
